alu_uart_sequencer: RTL
=======================

// Module: alu_uart_sequencer
// PURPOSE
//  Command sequencer that feeds the combinational ALU from a byte-stream receiver and returns the result to a byte transmitter.
//  Collects three bytes in order (dato_a, dato_b, opcode), validates the opcode, drives the ALU operands, registers the result and hands it to TX.
//  Sits between the UART rx/tx blocks and the ALU instance in the top level.
// PARAMETERS
//  NB_DATA         8     byte / operand / result width
//  NB_OPCODE       6     ALU opcode width
//  TIMEOUT_CYCLES  1000  max idle cycles between bytes of one command; 0 disables the timeout
// PORTS
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          asynchronous reset, active low
//  rx_data      in   NB_DATA    received byte, valid only when rx_valid=1
//  rx_valid     in   1          one-cycle strobe, new byte available
//  tx_busy      in   1          transmitter busy; tx_start is not accepted while high
//  tx_done      in   1          one-cycle strobe, byte fully sent
//  tx_data      out  NB_DATA    byte to send; held stable from tx_start until tx_done
//  tx_start     out  1          one-cycle pulse, begin transmission
//  alu_dato_a   out  NB_DATA    registered operand A to the ALU
//  alu_dato_b   out  NB_DATA    registered operand B to the ALU
//  alu_opcode   out  NB_OPCODE  registered opcode to the ALU
//  alu_result   in   NB_DATA    ALU output (combinational from alu_* outputs)
//  op_err       out  1          one-cycle pulse, invalid opcode byte rejected
//  timeout      out  1          one-cycle pulse, command aborted on inter-byte timeout
//  rx_overrun   out  1          one-cycle pulse, byte received while not accepting and dropped
//  state        out  3          current FSM state, for debug
// BEHAVIOUR
//  Reset (async, rst_n=0): state=GET_A, timeout counter=0, and every output=0.
//   Reset mid-command aborts immediately; any partial command is discarded.
//  FSM state encoding:
//   GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SEND=4, WAIT_TX=5. Codes 6-7 return to GET_A.
//  GET_A: on rx_valid -> alu_dato_a<=rx_data, go to GET_B. No timeout in this state.
//  GET_B: on rx_valid -> alu_dato_b<=rx_data, go to GET_OP.
//  GET_OP: on rx_valid, the byte is valid iff bits [NB_DATA-1:NB_OPCODE] are 0 and bits [NB_OPCODE-1:0] are one of:
//   100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR.
//   Valid byte -> alu_opcode<=low bits, go to EXEC.
//   Invalid byte -> op_err pulse next cycle; stay in GET_OP; A and B are kept; timeout counter is cleared.
//  EXEC: exactly 1 cycle; tx_data<=alu_result; go to SEND.
//  SEND: when tx_busy=0, pulse tx_start for one cycle and go to WAIT_TX; otherwise wait in SEND.
//  WAIT_TX: on tx_done, go to GET_A.
//   alu_dato_a, alu_dato_b and alu_opcode hold their values until overwritten by the next command.
//  Latency: opcode byte strobe at cycle N -> EXEC at N+1 -> tx_start at N+2 (if tx_busy=0).
//  Timeout (GET_B, GET_OP only):
//   The counter clears on state entry and on every rx_valid, and increments each cycle with rx_valid=0.
//   When the counter equals TIMEOUT_CYCLES-1 and rx_valid=0: next state GET_A, timeout pulse next cycle.
//   If rx_valid arrives in the same cycle, the byte wins and no timeout occurs.
//  Overrun: rx_valid in EXEC, SEND or WAIT_TX -> byte dropped, rx_overrun pulse next cycle, state unaffected.
//   This includes the cycle in which tx_done arrives in WAIT_TX.
//  Arithmetic and result width are defined by the ALU; result is truncated to NB_DATA (wrap-around, no carry reported).
//  All pulse outputs (tx_start, op_err, timeout, rx_overrun) are registered and high for exactly one cycle.
// TESTING
//  1. Bytes 0x05, 0x03, 0x20 with tx_busy=0 -> alu_opcode=0x20; one tx_start 2 cycles after the opcode strobe; tx_data=0x08.
//  2. Bytes 0x03, 0x05, 0x22 -> tx_data=0xFE (SUB wraps); next 0xF0, 0x0F, 0x27 -> tx_data=0x00 (NOR).
//  3. Bytes 0xAA, 0x0F, 0x21 -> op_err pulse, state=GET_OP; then 0x24 -> tx_data=0x0A (AND); 0xE0 is also rejected.
//  4. TIMEOUT_CYCLES=10: byte 0x11, then 10 idle cycles -> timeout pulse, state=GET_A; then 0x01, 0x02, 0x20 -> tx_data=0x03.
//  5. tx_busy held at 1 for 20 cycles after EXEC -> no tx_start until tx_busy falls; rx_valid during WAIT_TX -> rx_overrun pulse, result unaffected.
//  6. rst_n low while in SEND -> all outputs 0 and state=GET_A asynchronously; a full command after release completes normally.

Source files
------------

// File: rtl/alu_uart_sequencer_if.sv
// Byte-stream / ALU bus between the command sequencer and its neighbours.
// master = sequencer side, slave = rx/tx/ALU side.
interface alu_uart_sequencer_if #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
);
  logic [NB_DATA-1:0]   rx_data;
  logic                 rx_valid;
  logic                 tx_busy;
  logic                 tx_done;
  logic [NB_DATA-1:0]   tx_data;
  logic                 tx_start;
  logic [NB_DATA-1:0]   alu_dato_a;
  logic [NB_DATA-1:0]   alu_dato_b;
  logic [NB_OPCODE-1:0] alu_opcode;
  logic [NB_DATA-1:0]   alu_result;

  modport master (
    input  rx_data, rx_valid, tx_busy, tx_done, alu_result,
    output tx_data, tx_start, alu_dato_a, alu_dato_b, alu_opcode
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, tx_done, alu_result,
    input  tx_data, tx_start, alu_dato_a, alu_dato_b, alu_opcode
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the receiver, drives the ALU operands
// and hands the registered result to the transmitter.
module alu_uart_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_uart_sequencer_if.master  bus,
  output logic                  op_err,
  output logic                  timeout,
  output logic                  rx_overrun,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [NB_DATA-1:0]   a_reg, a_next;
  logic [NB_DATA-1:0]   b_reg, b_next;
  logic [NB_OPCODE-1:0] op_reg, op_next;
  logic [NB_DATA-1:0]   tx_data_reg, tx_data_next;
  logic                 tx_start_reg, tx_start_next;
  logic                 op_err_reg, op_err_next;
  logic                 timeout_reg, timeout_next;
  logic                 overrun_reg, overrun_next;
  logic                 to_hit;
  logic                 counting;

  function automatic logic opcode_ok(input logic [NB_DATA-1:0] b);
    logic [NB_OPCODE-1:0] lo;
    lo = b[NB_OPCODE-1:0];
    return (b[NB_DATA-1:NB_OPCODE] == '0) &&
           (lo inside {NB_OPCODE'(6'b100000), NB_OPCODE'(6'b100010),
                       NB_OPCODE'(6'b100100), NB_OPCODE'(6'b100101),
                       NB_OPCODE'(6'b100110), NB_OPCODE'(6'b000011),
                       NB_OPCODE'(6'b000010), NB_OPCODE'(6'b100111)});
  endfunction

  assign counting = TO_EN && ((state_reg == GET_B) || (state_reg == GET_OP));
  assign to_hit   = counting && (cnt_reg == CNT_MAX) && !bus.rx_valid;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    op_next       = op_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    op_err_next   = 1'b0;
    timeout_next  = 1'b0;
    overrun_next  = bus.rx_valid &&
                    ((state_reg == EXEC) || (state_reg == SEND) || (state_reg == WAIT_TX));

    case (state_reg)
      GET_A: begin
        if (bus.rx_valid) begin
          a_next     = bus.rx_data;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (bus.rx_valid) begin
          b_next     = bus.rx_data;
          state_next = GET_OP;
        end else if (to_hit) begin
          state_next   = GET_A;
          timeout_next = 1'b1;
        end
      end
      GET_OP: begin
        if (bus.rx_valid) begin
          if (opcode_ok(bus.rx_data)) begin
            op_next    = bus.rx_data[NB_OPCODE-1:0];
            state_next = EXEC;
          end else begin
            op_err_next = 1'b1;
          end
        end else if (to_hit) begin
          state_next   = GET_A;
          timeout_next = 1'b1;
        end
      end
      EXEC: begin
        tx_data_next  = bus.alu_result;
        state_next    = SEND;
        // Look ahead so the registered start lands in the first SEND cycle.
        tx_start_next = !bus.tx_busy;
      end
      SEND: begin
        if (tx_start_reg) begin
          state_next = WAIT_TX;
        end else begin
          tx_start_next = !bus.tx_busy;
        end
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          state_next = GET_A;
        end
      end
      default: state_next = GET_A;
    endcase

    if (!counting || bus.rx_valid || (state_next != state_reg)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= GET_A;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      op_err_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= op_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      op_err_reg   <= op_err_next;
      timeout_reg  <= timeout_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign bus.alu_dato_a = a_reg;
  assign bus.alu_dato_b = b_reg;
  assign bus.alu_opcode = op_reg;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_start   = tx_start_reg;
  assign op_err         = op_err_reg;
  assign timeout        = timeout_reg;
  assign rx_overrun     = overrun_reg;
  assign state          = state_reg;

endmodule
